// File: rtl/vwrite_pp.sv
// Double-buffered Versat write unit: a loop-addressed fill engine writes in0 into a 2-port
// buffer while a drain engine bursts a linear region onto the databus. Optional VWRITE_PP_REVERSE_EN adds bit-reversed fill addressing.
//
// state   | meaning
// F_IDLE  | fill engine waiting for an accepted run
// F_DELAY | fill engine counting down delayB before the first loop cycle
// F_LOOP  | fill engine stepping p/it, writing in0 while p < dutyB
// D_IDLE  | drain engine waiting for an accepted run
// D_READ  | buffer read of the next word is issued
// D_XFER  | word presented on the databus, held until ready
module vwrite_pp #(
   parameter int DATA_W     = 32,
   parameter int MEM_ADDR_W = 10,
   parameter int IO_ADDR_W  = 32,
   parameter int SIZE_W     = 10,
   parameter int PERIOD_W   = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   output logic                  done,
   output logic                  databus_valid,
   input  logic                  databus_ready,
   output logic [IO_ADDR_W-1:0]  databus_addr,
   output logic [DATA_W-1:0]     databus_wdata,
   output logic [DATA_W/8-1:0]   databus_wstrb,
   input  logic [DATA_W-1:0]     in0,
   input  logic [IO_ADDR_W-1:0]  ext_addr,
   input  logic [MEM_ADDR_W-1:0] int_addr,
   input  logic [SIZE_W-1:0]     size,
   input  logic                  pingPong,
   input  logic [MEM_ADDR_W-1:0] startB,
   input  logic [MEM_ADDR_W-1:0] incrB,
   input  logic [MEM_ADDR_W-1:0] shiftB,
   input  logic [MEM_ADDR_W-1:0] iterB,
   input  logic [PERIOD_W-1:0]   perB,
   input  logic [PERIOD_W-1:0]   dutyB,
   input  logic [PERIOD_W-1:0]   delayB
`ifdef VWRITE_PP_REVERSE_EN
   ,
   input  logic                  reverseB
`endif
);

   localparam int BANK_W = MEM_ADDR_W - 1;
   localparam int STRB_W = DATA_W / 8;
   localparam int DEPTH  = 1 << MEM_ADDR_W;

   typedef enum logic [1:0] {F_IDLE, F_DELAY, F_LOOP} fill_state_t;
   typedef enum logic [1:0] {D_IDLE, D_READ, D_XFER} drain_state_t;

   fill_state_t  r_fill_state, w_fill_next;
   drain_state_t r_drain_state, w_drain_next;

   logic [DATA_W-1:0]     r_mem [DEPTH];

   logic                  r_done;
   logic                  r_last_fill;
   logic                  r_ping;
   logic                  r_fill_bank;
   logic                  r_drain_bank;
   logic [MEM_ADDR_W-1:0] r_incrB;
   logic [MEM_ADDR_W-1:0] r_shiftB;
   logic [MEM_ADDR_W-1:0] r_iterB;
   logic [PERIOD_W-1:0]   r_perB;
   logic [PERIOD_W-1:0]   r_dutyB;
`ifdef VWRITE_PP_REVERSE_EN
   logic                  r_rev;
`endif

   logic [MEM_ADDR_W-1:0] r_faddr;
   logic [PERIOD_W-1:0]   r_p;
   logic [MEM_ADDR_W-1:0] r_it;
   logic [PERIOD_W-1:0]   r_dly;

   logic [MEM_ADDR_W-1:0] r_rd_ptr;
   logic [SIZE_W-1:0]     r_k;
   logic [SIZE_W-1:0]     r_size;
   logic [IO_ADDR_W-1:0]  r_ext_cur;
   logic                  r_valid;
   logic [IO_ADDR_W-1:0]  r_bus_addr;
   logic [DATA_W-1:0]     r_wdata;

   logic                  w_accept;
   logic                  w_we;
   logic                  w_last_p;
   logic                  w_fill_last;
   logic [MEM_ADDR_W-1:0] w_faddr_next;
   logic [MEM_ADDR_W-1:0] w_waddr_log;
   logic [MEM_ADDR_W-1:0] w_waddr;
   logic [MEM_ADDR_W-1:0] w_raddr;
   logic [SIZE_W-1:0]     w_k_next;

   assign w_accept = run & r_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_done       <= 1'b1;
         r_last_fill  <= 1'b1;
         r_ping       <= 1'b0;
         r_fill_bank  <= 1'b0;
         r_drain_bank <= 1'b0;
         r_incrB      <= '0;
         r_shiftB     <= '0;
         r_iterB      <= '0;
         r_perB       <= '0;
         r_dutyB      <= '0;
`ifdef VWRITE_PP_REVERSE_EN
         r_rev        <= 1'b0;
`endif
      end else begin
         r_done <= w_accept ? 1'b0 :
                   (r_fill_state == F_IDLE) && (r_drain_state == D_IDLE);
         if (w_accept) begin
            r_ping   <= pingPong;
            r_incrB  <= incrB;
            r_shiftB <= shiftB;
            r_iterB  <= iterB;
            r_perB   <= perB;
            r_dutyB  <= dutyB;
`ifdef VWRITE_PP_REVERSE_EN
            r_rev    <= reverseB;
`endif
            if (pingPong) begin
               r_fill_bank  <= ~r_last_fill;
               r_drain_bank <= r_last_fill;
               r_last_fill  <= ~r_last_fill;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fill_state  <= F_IDLE;
         r_drain_state <= D_IDLE;
      end else begin
         r_fill_state  <= w_fill_next;
         r_drain_state <= w_drain_next;
      end
   end

   always_comb begin
      w_fill_next = r_fill_state;
      w_we        = 1'b0;
      w_last_p    = (r_p == r_perB - PERIOD_W'(1));
      w_fill_last = w_last_p && (r_it == r_iterB - MEM_ADDR_W'(1));
      case (r_fill_state)
         F_IDLE: begin
            if (w_accept && (iterB != '0) && (perB != '0))
               w_fill_next = (delayB == '0) ? F_LOOP : F_DELAY;
         end
         F_DELAY: begin
            if (r_dly == PERIOD_W'(1))
               w_fill_next = F_LOOP;
         end
         F_LOOP: begin
            w_we = (r_p < r_dutyB);
            if (w_fill_last)
               w_fill_next = F_IDLE;
         end
         default: w_fill_next = F_IDLE;
      endcase
   end

   assign w_faddr_next = r_faddr + (w_we ? r_incrB : '0) + (w_last_p ? r_shiftB : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_faddr <= '0;
         r_p     <= '0;
         r_it    <= '0;
         r_dly   <= '0;
      end else begin
         case (r_fill_state)
            F_IDLE: begin
               if (w_accept) begin
                  r_faddr <= startB;
                  r_p     <= '0;
                  r_it    <= '0;
                  r_dly   <= delayB;
               end
            end
            F_DELAY: r_dly <= r_dly - PERIOD_W'(1);
            F_LOOP: begin
               r_faddr <= w_faddr_next;
               if (w_last_p) begin
                  r_p  <= '0;
                  r_it <= r_it + MEM_ADDR_W'(1);
               end else begin
                  r_p  <= r_p + PERIOD_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // In ping-pong mode only the within-bank bits are reversed; the bank bit is overlaid below.
   always_comb begin
      w_waddr_log = r_faddr;
`ifdef VWRITE_PP_REVERSE_EN
      if (r_rev) begin
         w_waddr_log = '0;
         if (r_ping) begin
            for (int i = 0; i < BANK_W; i++)
               w_waddr_log[i] = r_faddr[BANK_W-1-i];
         end else begin
            for (int i = 0; i < MEM_ADDR_W; i++)
               w_waddr_log[i] = r_faddr[MEM_ADDR_W-1-i];
         end
      end
`endif
      w_waddr = r_ping ? {r_fill_bank, w_waddr_log[BANK_W-1:0]} : w_waddr_log;
   end

   always_ff @(posedge clk) begin
      if (w_we && !rst)
         r_mem[w_waddr] <= in0;
   end

   assign w_k_next = r_k + SIZE_W'(1);
   assign w_raddr  = r_ping ? {r_drain_bank, r_rd_ptr[BANK_W-1:0]} : r_rd_ptr;

   always_comb begin
      w_drain_next = r_drain_state;
      case (r_drain_state)
         D_IDLE: if (w_accept && (size != '0)) w_drain_next = D_READ;
         D_READ: w_drain_next = D_XFER;
         D_XFER: begin
            if (databus_ready)
               w_drain_next = (w_k_next == r_size) ? D_IDLE : D_READ;
         end
         default: w_drain_next = D_IDLE;
      endcase
   end

   // The buffer read register doubles as the databus write-data register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr   <= '0;
         r_k        <= '0;
         r_size     <= '0;
         r_ext_cur  <= '0;
         r_valid    <= 1'b0;
         r_bus_addr <= '0;
         r_wdata    <= '0;
      end else begin
         case (r_drain_state)
            D_IDLE: begin
               if (w_accept) begin
                  r_rd_ptr  <= int_addr;
                  r_k       <= '0;
                  r_size    <= size;
                  r_ext_cur <= ext_addr;
               end
            end
            D_READ: begin
               r_wdata    <= r_mem[w_raddr];
               r_bus_addr <= r_ext_cur;
               r_valid    <= 1'b1;
            end
            D_XFER: begin
               if (databus_ready) begin
                  r_valid   <= 1'b0;
                  r_k       <= w_k_next;
                  r_rd_ptr  <= r_rd_ptr + MEM_ADDR_W'(1);
                  r_ext_cur <= r_ext_cur + IO_ADDR_W'(STRB_W);
               end
            end
            default: ;
         endcase
      end
   end

   assign done          = r_done;
   assign databus_valid = r_valid;
   assign databus_addr  = r_bus_addr;
   assign databus_wdata = r_wdata;
   assign databus_wstrb = {STRB_W{r_valid}};

endmodule
